// File: rtl/vec_window_proc_if.sv
// Streaming bus for vec_window_proc.
//
// Handshake rules (both directions): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holding valid must keep its data
// stable until the transfer. Ready may depend combinationally on the other
// side's signals.
//
// Signals:
//   in_valid  - source offers next_in/mode
//   in_ready  - processor can accept a sample this cycle
//   next_in   - unsigned WIDTH-bit sample
//   mode      - reduction select: 00 sum, 01 max, 10 min, 11 xor
//   out_valid - f holds a result
//   out_ready - consumer takes f this cycle
//   f         - unsigned ACC_W-bit result
//
// Modports: master = sample source / result consumer side, slave = processor.
interface vec_window_proc_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
);
    localparam int ACC_W = WIDTH + $clog2(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] next_in;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] f;

    modport master (
        output in_valid, next_in, mode, out_ready,
        input  in_ready, out_valid, f
    );

    modport slave (
        input  in_valid, next_in, mode, out_ready,
        output in_ready, out_valid, f
    );
endinterface

// File: rtl/vec_window_proc.sv
// vec_window_proc: sliding-window vector processor.
//
// Shifts WIDTH-bit samples into a DEPTH-entry window. Once the window is
// full, every accepted sample yields one reduction (sum/max/min/xor) over the
// post-shift window, registered with a latency of one cycle into a 1-deep
// output register.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-low reset
//   clear    - synchronous flush of window and output (beats accept/out_ready)
//   bus      - vec_window_proc_if.slave (in_valid/in_ready/next_in/mode,
//              out_valid/out_ready/f)
//   fill_cnt - valid samples in the window, saturates at DEPTH
//   taps     - only with VWP_DEBUG_TAPS_EN: live window, tap k at
//              [k*WIDTH +: WIDTH], tap 0 is the newest sample
//
// Configuration macro: VWP_DEBUG_TAPS_EN adds the taps debug port.
// Function and timing are identical with or without it.
module vec_window_proc #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    vec_window_proc_if.slave             bus,
`ifdef VWP_DEBUG_TAPS_EN
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic [DEPTH*WIDTH-1:0]       taps
`else
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
`endif
);

    localparam int ACC_W = WIDTH + $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] win_q    [DEPTH];
    logic [WIDTH-1:0] win_next [DEPTH];
    logic [CNT_W-1:0] fill_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] f_q;

    logic             accept;
    logic             produce;

    logic [ACC_W-1:0] red_sum;
    logic [WIDTH-1:0] red_max;
    logic [WIDTH-1:0] red_min;
    logic [WIDTH-1:0] red_xor;
    logic [ACC_W-1:0] result;

    // The output register is 1 deep; a full register can still take a new
    // result in the same cycle the consumer drains it.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    // This accept fills (or keeps full) the window, so it yields a result.
    assign produce       = accept && (fill_q >= LAST_CNT);

    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign fill_cnt      = fill_q;

    // Post-shift window: the reduction is taken over what the window holds
    // after this sample goes in.
    always_comb begin
        win_next[0] = bus.next_in;
        for (int k = 1; k < DEPTH; k++) begin
            win_next[k] = win_q[k-1];
        end
    end

    always_comb begin
        red_sum = '0;
        red_max = win_next[0];
        red_min = win_next[0];
        red_xor = '0;
        for (int k = 0; k < DEPTH; k++) begin
            red_sum = red_sum + ACC_W'(win_next[k]);
            red_xor = red_xor ^ win_next[k];
            if (win_next[k] > red_max) red_max = win_next[k];
            if (win_next[k] < red_min) red_min = win_next[k];
        end
    end

    always_comb begin
        result = '0;
        case (bus.mode)
            2'b00:   result = red_sum;
            2'b01:   result = ACC_W'(red_max);
            2'b10:   result = ACC_W'(red_min);
            default: result = ACC_W'(red_xor);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                win_q[k] <= '0;
            end
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                win_q[k] <= '0;
            end
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < DEPTH; k++) begin
                    win_q[k] <= win_next[k];
                end
                if (fill_q != FULL_CNT) fill_q <= fill_q + 1'b1;
            end
            if (produce) begin
                f_q         <= result;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                // Drained with nothing new: f keeps its last value.
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef VWP_DEBUG_TAPS_EN
    always_comb begin
        taps = '0;
        for (int k = 0; k < DEPTH; k++) begin
            taps[k*WIDTH +: WIDTH] = win_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_vec_window_proc.sv
module tb_vec_window_proc;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int ACC_W = WIDTH + $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    logic clear;
    logic [CNT_W-1:0] fill_cnt;
`ifdef VWP_DEBUG_TAPS_EN
    logic [DEPTH*WIDTH-1:0] taps;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_window_proc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    vec_window_proc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus.slave),
`ifdef VWP_DEBUG_TAPS_EN
        .fill_cnt (fill_cnt),
        .taps     (taps)
`else
        .fill_cnt (fill_cnt)
`endif
    );

    // ---------------- reference model ----------------
    // Window kept as a queue, newest sample at index 0.
    logic [WIDTH-1:0] win[$];
    logic             m_ov;
    logic [ACC_W-1:0] m_f;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [ACC_W-1:0] ref_reduce(input logic [1:0] m);
        int acc;
        acc = (m == 2'b10) ? 255 : 0;
        foreach (win[i]) begin
            case (m)
                2'b00: acc = acc + int'(win[i]);
                2'b01: if (int'(win[i]) > acc) acc = int'(win[i]);
                2'b10: if (int'(win[i]) < acc) acc = int'(win[i]);
                default: acc = acc ^ int'(win[i]);
            endcase
        end
        return ACC_W'(acc);
    endfunction

    function automatic logic m_in_ready();
        return !m_ov || bus.out_ready;
    endfunction

    task automatic model_reset();
        win.delete();
        m_ov = 1'b0;
        m_f  = '0;
    endtask

    // Applies one clock edge of the spec's rules to the model, using the
    // inputs currently driven.
    task automatic model_step();
        logic acc_ok;
        acc_ok = bus.in_valid && m_in_ready();
        if (clear) begin
            model_reset();
        end else if (acc_ok) begin
            win.push_front(bus.next_in);
            if (win.size() > DEPTH) void'(win.pop_back());
            if (win.size() == DEPTH) begin
                m_f  = ref_reduce(bus.mode);
                m_ov = 1'b1;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_ov));
        check({tag, ".f"},         64'(bus.f),         64'(m_f));
        check({tag, ".fill_cnt"},  64'(fill_cnt),      64'(win.size()));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] m,
                         input logic ordy, input logic clr);
        bus.in_valid  = v;
        bus.next_in   = d;
        bus.mode      = m;
        bus.out_ready = ordy;
        clear         = clr;
    endtask

    // One clock: check in_ready before the edge, step the model, check after.
    task automatic tick(input string tag);
        #1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(m_in_ready()));
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] m, input string tag);
        drive(1'b1, d, m, 1'b1, 1'b0);
        tick(tag);
    endtask

    task automatic do_clear();
        drive(1'b0, '0, 2'b00, 1'b1, 1'b1);
        tick("clear");
        drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
    endtask

    logic [ACC_W-1:0] f_hold;
    logic [CNT_W-1:0] fill_hold;

    initial begin
        drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
        reset = 1'b0;
        model_reset();
        #2;
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.f",         64'(bus.f),         64'd0);
        check("reset.fill_cnt",  64'(fill_cnt),      64'd0);
        #5 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.in_ready", 64'(bus.in_ready), 64'd1);

        // 1. Fill + sum
        push(8'hff, 2'b00, "fill0");
        push(8'h8f, 2'b00, "fill1");
        push(8'hde, 2'b00, "fill2");
        check("fill2.no_out", 64'(bus.out_valid), 64'd0);
        push(8'h1a, 2'b00, "fill3");
        check("sum_first", 64'(bus.f), 64'h286);
        check("sum_first_valid", 64'(bus.out_valid), 64'd1);
        push(8'h34, 2'b00, "fill4");
        check("sum_steady", 64'(bus.f), 64'h1bb);

        // 2. Modes over window 8f,de,1a,1a
        for (int m = 1; m < 4; m++) begin
            do_clear();
            push(8'hff, 2'b00, "mload");
            push(8'h8f, 2'b00, "mload");
            push(8'hde, 2'b00, "mload");
            push(8'h1a, 2'b00, "mload");
            push(8'h1a, 2'(m), "mode");
            if (m == 1) check("mode_max", 64'(bus.f), 64'h0de);
            if (m == 2) check("mode_min", 64'(bus.f), 64'h01a);
        end
        do_clear();
        push(8'hff, 2'b00, "mload4");
        push(8'h8f, 2'b00, "mload4");
        push(8'hde, 2'b00, "mload4");
        push(8'h1a, 2'b01, "mload4");
        check("mode_max_first", 64'(bus.f), 64'h0ff);

        // 3. Back-pressure
        f_hold    = bus.f;
        fill_hold = fill_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h77, 2'b00, 1'b0, 1'b0);
            tick("bp_hold");
            check("bp_f_stable", 64'(bus.f), 64'(f_hold));
            check("bp_fill_stable", 64'(fill_cnt), 64'(fill_hold));
        end
        drive(1'b1, 8'h77, 2'b00, 1'b1, 1'b0);
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick("bp_release");
        check("bp_release_sum", 64'(bus.f), 64'(8'h77 + 8'h1a + 8'hde + 8'h8f));
        drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
        tick("bp_drain");
        check("bp_drain_valid", 64'(bus.out_valid), 64'd0);

        // 4. Overflow width
        for (int i = 0; i < 4; i++) push(8'hff, 2'b00, "ovf");
        check("ovf_sum", 64'(bus.f), 64'h3fc);

        // 5. Clear discards offered sample
        drive(1'b1, 8'h55, 2'b00, 1'b1, 1'b1);
        tick("clear55");
        check("clear.fill", 64'(fill_cnt), 64'd0);
        check("clear.f", 64'(bus.f), 64'd0);
        push(8'h01, 2'b00, "refill");
        push(8'h02, 2'b00, "refill");
        push(8'h03, 2'b00, "refill");
        check("refill.no_out", 64'(bus.out_valid), 64'd0);
        push(8'h04, 2'b00, "refill");
        check("refill.sum", 64'(bus.f), 64'd10);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 39) == 0));
            tick("rand");
        end

        // 6. Async reset mid-stream while out_valid=1
        drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)), 2'b00, "pre_rst");
        drive(1'b0, '0, 2'b00, 1'b0, 1'b0);
        check("pre_rst.valid", 64'(bus.out_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst.out_valid", 64'(bus.out_valid), 64'd0);
        check("arst.f",         64'(bus.f),         64'd0);
        check("arst.fill_cnt",  64'(fill_cnt),      64'd0);
        check("arst.in_ready",  64'(bus.in_ready),  64'd1);
`ifdef VWP_DEBUG_TAPS_EN
        check("arst.taps",      64'(taps),          64'd0);
`endif
        #2 reset = 1'b1;
        push(8'h10, 2'b00, "after_rst");
        push(8'h20, 2'b00, "after_rst");
        push(8'h30, 2'b00, "after_rst");
        push(8'h40, 2'b00, "after_rst");
        check("after_rst.sum", 64'(bus.f), 64'h0a0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
